ix_uop_sequencer: RTL

//  Sequences multi-uop instructions through the execute-stage ALU (shift/rotate/add datapath).

---
 rtl/ix_uop_sequencer_if.sv | 45 ++++
 rtl/ix_uop_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/ix_uop_sequencer_if.sv
// Bus bundle between ID/IX register, the uop sequencer, the ALU and IX/MEM writeback.
// slave = sequencer side; master = surrounding pipeline (issue source, ALU, writeback sink).
interface ix_uop_sequencer_if #(
  parameter int UOP_W  = 5,
  parameter int DATA_W = 16
);
  // instruction handoff from ID/IX
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_opcode;
  logic [UOP_W-1:0]  in_uop_cnt;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [2:0]        in_dest;
  // pipeline control
  logic              stall;
  logic              flush;
  // ALU uop issue and result return
  logic              uop_valid;
  logic [4:0]        uop_opcode;
  logic [DATA_W-1:0] uop_a;
  logic [DATA_W-1:0] uop_b;
  logic [UOP_W-1:0]  uop_idx;
  logic              uop_last;
  logic [DATA_W-1:0] alu_result;
  // writeback
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wb_dest;
  logic              busy;

  modport slave (
    input  in_valid, in_opcode, in_uop_cnt, in_rs_val, in_rt_val, in_dest,
    input  stall, flush, alu_result,
    output in_ready, uop_valid, uop_opcode, uop_a, uop_b, uop_idx, uop_last,
    output wb_valid, wb_data, wb_dest, busy
  );

  modport master (
    output in_valid, in_opcode, in_uop_cnt, in_rs_val, in_rt_val, in_dest,
    output stall, flush, alu_result,
    input  in_ready, uop_valid, uop_opcode, uop_a, uop_b, uop_idx, uop_last,
    input  wb_valid, wb_data, wb_dest, busy
  );
endinterface

// File: rtl/ix_uop_sequencer.sv
// Execute-stage uop sequencer: issues N back-to-back ALU uops per instruction, feeding each
// result back as operand A, then presents the final accumulator for writeback.
module ix_uop_sequencer #(
  parameter int UOP_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ix_uop_sequencer_if.slave sif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // per-instruction fields that stay constant across all of its uops
  typedef struct packed {
    logic [4:0]        opcode;
    logic [2:0]        dest;
    logic [DATA_W-1:0] opnd_b;
    logic [UOP_W-1:0]  last_idx;
  } instr_t;

  state_t            state, state_nxt;
  instr_t            ins;
  logic [DATA_W-1:0] acc;
  logic [UOP_W-1:0]  idx;

  logic              accept;
  logic              advance;
  logic              is_last;
  logic [UOP_W-1:0]  last_idx_in;

  // a zero count still runs one uop
  assign last_idx_in = (sif.in_uop_cnt == '0) ? '0 : sif.in_uop_cnt - UOP_W'(1);
  assign accept      = (state == S_IDLE) && sif.in_valid && !sif.flush;
  assign advance     = (state == S_RUN) && !sif.stall && !sif.flush;
  assign is_last     = (idx == ins.last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state and all bus outputs; data outputs are zeroed outside their owning state
  always_comb begin
    state_nxt      = state;
    sif.in_ready   = 1'b0;
    sif.busy       = 1'b1;
    sif.uop_valid  = 1'b0;
    sif.uop_opcode = '0;
    sif.uop_a      = '0;
    sif.uop_b      = '0;
    sif.uop_idx    = '0;
    sif.uop_last   = 1'b0;
    sif.wb_valid   = 1'b0;
    sif.wb_data    = '0;
    sif.wb_dest    = '0;
    case (state)
      S_IDLE: begin
        sif.in_ready = 1'b1;
        sif.busy     = 1'b0;
        if (accept) state_nxt = S_RUN;
      end
      S_RUN: begin
        sif.uop_valid  = 1'b1;
        sif.uop_opcode = ins.opcode;
        sif.uop_a      = acc;
        sif.uop_b      = ins.opnd_b;
        sif.uop_idx    = idx;
        sif.uop_last   = is_last;
        if (sif.flush)                 state_nxt = S_IDLE;
        else if (!sif.stall && is_last) state_nxt = S_WB;
      end
      S_WB: begin
        sif.wb_valid = 1'b1;
        sif.wb_data  = acc;
        sif.wb_dest  = ins.dest;
        if (sif.flush || !sif.stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // accumulator / index datapath; a stalled uop keeps presenting identical operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins <= '0;
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      ins.opcode   <= sif.in_opcode;
      ins.dest     <= sif.in_dest;
      ins.opnd_b   <= sif.in_rt_val;
      ins.last_idx <= last_idx_in;
      acc          <= sif.in_rs_val;
      idx          <= '0;
    end else if (advance) begin
      acc <= sif.alu_result;
      // last_idx never exceeds 2**UOP_W-2, so this increment cannot wrap
      if (!is_last) idx <= idx + UOP_W'(1);
    end
  end

endmodule
